// File: rtl/approx_div16x8_pkg.sv
// Shared types and constants for the 16/8 restoring divider.
package approx_div_pkg;

    localparam int DW   = 8;
    localparam int ITER = 8;

    localparam logic [DW-1:0] QUOT_OVF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/approx_div16x8_if.sv
// Start/done handshake and operand/result bus of the divider.
interface approx_div16x8_if;

    logic                               start;
    logic [2*approx_div_pkg::DW-1:0]    dividend;
    logic [approx_div_pkg::DW-1:0]      divisor;
    logic                               busy;
    logic                               done;
    logic [approx_div_pkg::DW-1:0]      quot;
    logic [approx_div_pkg::DW-1:0]      rem;
    logic                               ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quot, rem, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quot, rem, ovf
    );

endinterface

// File: rtl/approx_div16x8_div_step.sv
// One combinational restoring-division iteration: shift in a bit, trial-subtract d.
module div_step
    import approx_div_pkg::*;
(
    input  logic [DW:0]   r_in,
    input  logic          bit_in,
    input  logic [DW-1:0] d,
    output logic [DW:0]   r_out,
    output logic          q_bit
);

    logic [DW:0] r_sh;

    always_comb begin
        // r_in stays below d, so its top bit is always 0 and dropping it loses nothing.
        r_sh = (DW+1)'({r_in, bit_in});
        if (r_sh >= {1'b0, d}) begin
            r_out = r_sh - {1'b0, d};
            q_bit = 1'b1;
        end else begin
            r_out = r_sh;
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/approx_div16x8.sv
// Sequential 16/8 restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_APPROX_EN to drop the divisor low nibble (approximate build).
module approx_div16x8
    import approx_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    approx_div16x8_if.slave   bus
);

    function automatic logic [DW-1:0] eff_divisor(input logic [DW-1:0] dv);
`ifdef DIV_APPROX_EN
        if (dv[DW-1:DW/2] != '0) return {dv[DW-1:DW/2], {(DW/2){1'b0}}};
        else                     return dv;
`else
        return dv;
`endif
    endfunction

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW:0]   r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] d_q, d_d;

    logic [DW:0]   step_r;
    logic          step_bit;
    logic [DW-1:0] d_new;
    logic          accept;

    div_step u_step (
        .r_in   (r_q),
        .bit_in (q_q[DW-1]),
        .d      (d_q),
        .r_out  (step_r),
        .q_bit  (step_bit)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        d_new   = eff_divisor(bus.divisor);
        accept  = bus.start && (state_q == IDLE || state_q == DONE);

        case (state_q)
            RUN: begin
                r_d   = step_r;
                q_d   = {q_q[DW-2:0], step_bit};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(ITER-1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = {q_q[DW-2:0], step_bit};
                    rem_d   = step_r[DW-1:0];
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                if (state_q == DONE) state_d = IDLE;
                if (accept) begin
                    d_d = d_new;
                    // Quotient would not fit in DW bits (or d is zero): answer immediately.
                    if (d_new == '0 || bus.dividend[2*DW-1:DW] >= d_new) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ovf_d   = 1'b1;
                        quot_d  = QUOT_OVF;
                        rem_d   = '0;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        r_d     = {1'b0, bus.dividend[2*DW-1:DW]};
                        q_d     = bus.dividend[DW-1:0];
                        cnt_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        r_q <= r_d;
        q_q <= q_d;
        d_q <= d_d;
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_approx_div16x8.sv
// Self-checking bench for approx_div16x8: directed cases plus random operands vs an arithmetic model.
module tb_approx_div16x8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    approx_div16x8_if bus ();

    approx_div16x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] model_d(input logic [7:0] b);
`ifdef DIV_APPROX_EN
        if (b[7:4] != 4'h0) return {b[7:4], 4'h0};
`endif
        return b;
    endfunction

    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic o);
        int d;
        d = int'(model_d(b));
        if (d == 0 || int'(a) / d > 255) begin
            q = 8'hFF; r = 8'h00; o = 1'b1;
        end else begin
            q = 8'(int'(a) / d); r = 8'(int'(a) % d); o = 1'b0;
        end
    endfunction

    // Wait (bounded) for done after the accepting edge; returns edges waited and busy cycles seen.
    task automatic wait_done(output int lat, output int nbusy);
        lat = 0; nbusy = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b,
                                input int lat, input int nbusy);
        logic [7:0] eq, er;
        logic       eo;
        model(a, b, eq, er, eo);
        chk({tag, " latency"}, lat, eo ? 0 : 8);
        chk({tag, " busy_cycles"}, nbusy, eo ? 0 : 8);
        chk({tag, " quot"}, bus.quot, eq);
        chk({tag, " rem"}, bus.rem, er);
        chk({tag, " ovf"}, bus.ovf, eo);
    endtask

    task automatic do_div(input string tag, input logic [15:0] a, input logic [7:0] b);
        int lat, nbusy;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat, nbusy);
        check_result(tag, a, b, lat, nbusy);
        @(posedge clk); #1;
        chk({tag, " done_drop"}, bus.done, 1'b0);
        chk({tag, " busy_after"}, bus.busy, 1'b0);
    endtask

    initial begin
        int lat, nbusy;
        logic [15:0] a;
        logic [7:0]  b;

        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset quot", bus.quot, 0);
        chk("reset rem",  bus.rem,  0);
        chk("reset ovf",  bus.ovf,  0);
        @(negedge clk); rst = 1'b0;

        // Directed values from the arithmetic, with exact-build constants spelled out.
        do_div("d1000_7", 16'h03E8, 8'h07);
`ifndef DIV_APPROX_EN
        chk("1000/7 const quot", bus.quot, 8'd142);
        chk("1000/7 const rem",  bus.rem,  8'd6);
`endif
        do_div("dFE01_FF", 16'hFE01, 8'hFF);
        do_div("div_zero", 16'h1234, 8'h00);
        do_div("ovf_1000_10", 16'h1000, 8'h10);
        do_div("d1000_1F", 16'h03E8, 8'h1F);
`ifdef DIV_APPROX_EN
        chk("approx 1000/31 quot", bus.quot, 8'd62);
        chk("approx 1000/31 rem",  bus.rem,  8'd8);
`else
        chk("exact 1000/31 quot", bus.quot, 8'd32);
        chk("exact 1000/31 rem",  bus.rem,  8'd8);
`endif

        // Start held through RUN; second operation accepted in the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'h5A5A; bus.divisor = 8'hC3;
        @(posedge clk); #1;
        bus.dividend = 16'h2710; bus.divisor = 8'h65;
        wait_done(lat, nbusy);
        check_result("b2b first", 16'h5A5A, 8'hC3, lat, nbusy);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b done_drop", bus.done, 1'b0);
        chk("b2b busy_rise", bus.busy, 1'b1);
        wait_done(lat, nbusy);
        // lat counted from one edge after the first done: 8 more edges makes 9 in total.
        check_result("b2b second", 16'h2710, 8'h65, lat, nbusy);

        // Reset in the 4th RUN cycle discards the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'h03E8; bus.divisor = 8'h07;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst busy", bus.busy, 0);
        chk("midrst done", bus.done, 0);
        chk("midrst quot", bus.quot, 0);
        chk("midrst rem",  bus.rem,  0);
        chk("midrst ovf",  bus.ovf,  0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst idle done", bus.done, 0);
        chk("midrst idle busy", bus.busy, 0);
        do_div("after_rst", 16'h03E8, 8'h07);

        // Random operands, mostly non-overflowing.
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            if (i % 8 == 0) b = 8'($urandom_range(0, 15));
            if (i % 4 != 0 && model_d(b) != 8'h00) a[15:8] = a[15:8] % model_d(b);
            do_div($sformatf("rand%0d", i), a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_div16x8.md
# approx_div16x8

Sequential restoring divider: a 16-bit dividend divided by an 8-bit divisor gives an 8-bit quotient and an 8-bit remainder, one quotient bit per clock. It is the inverse datapath of the 8x8 approximate multipliers: it takes 16-bit products back to 8-bit operands for accuracy characterisation and recovery. A compile-time option makes it approximate in the same way the multipliers are, by discarding the divisor low nibble. It sits behind the multiplier test harness and uses a start/done handshake.

## Interface
- DW, 8, operand/quotient width; dividend is 2*DW bits; only 8 is verified
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when the block is ready (IDLE or DONE)
- dividend  in  16  numerator; sampled with an accepted start
- divisor  in  8  denominator; sampled with an accepted start
- busy  out  1  high in RUN
- done  out  1  high for exactly one cycle in DONE
- quot  out  8  quotient; held from DONE until the next accepted start
- rem  out  8  remainder; held likewise
- ovf  out  1  divide-by-zero or quotient > 255; held likewise

## Operation
- States:
  - IDLE: after reset.
  - RUN: 8 iterations; 3-bit counter.
  - DONE: one cycle.
- Accepted start (state IDLE or DONE, start=1):
  - Latch the effective divisor d and the dividend.
  - If d==0 or dividend[15:8] >= d: go to DONE with ovf=1, quot=8'hFF, rem=8'h00.
  - Otherwise: R = {1'b0, dividend[15:8]} (9-bit partial remainder), Q = dividend[7:0] (shift register), counter = 0, go to RUN.
- Each RUN cycle:
  - R' = {R[7:0], Q[7]}; Q shifts left.
  - If R' >= {1'b0, d}: R = R' - d and shift in 1. Else R = R' and shift in 0.
  - Counter increments. After iteration 8, go to DONE.
- Entering DONE from RUN:
  - quot = Q, rem = R[7:0], ovf = 0.
  - Invariant: quot*d + rem == dividend with rem < d. Using d here makes the invariant also hold in the approximate build.
- DONE moves to IDLE, or to RUN/DONE if start=1 in that cycle (back-to-back operation).
- start in RUN is ignored; it is not queued.
- rst at any time, including mid-RUN:
  - Next state IDLE.
  - busy=0, done=0, quot=0, rem=0, ovf=0, counter=0.
  - The operation in flight is discarded.

## Timing
- All outputs are registered; reset value is 0 for every output.
- Accepted at edge E, normal path: busy=1 from E to E+8; done=1 from E+8 to E+9; latency 8 cycles.
- Accepted at edge E, overflow or zero path: done=1 from E to E+1; busy stays 0; latency 1 cycle.
- Start accepted in the DONE cycle: done still drops at the next edge, and busy rises at that same edge.
- Throughput: one division per 9 cycles.

## Configuration
- DIV_APPROX_EN defined:
  - d = {divisor[7:4], 4'b0000} when divisor[7:4] != 0, else divisor.
  - The overflow check, the iterations and the remainder all use this d.
- DIV_APPROX_EN undefined: d = divisor, and the result is exact.
- Latency, handshake and reset behaviour are identical in both builds.

## Structure
- Package approx_div_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the DW and ITER (=8) constants;
  - the quot value on overflow (8'hFF).
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: R (9 bits), the incoming bit, d.
  - Outputs: next R and the quotient bit.
  - Instantiated once in the FSM datapath.

## Test plan
- 0x03E8 / 0x07, exact build -> after 8 busy cycles, done pulse with quot=142 (0x8E), rem=6, ovf=0.
- 0xFE01 / 0xFF -> quot=0xFF, rem=0x00, ovf=0.
- 0x1234 / 0x00, then 0x1000 / 0x10 -> each gives done on the next cycle with ovf=1, quot=0xFF, rem=0, and busy never asserted.
- DIV_APPROX_EN, 0x03E8 / 0x1F -> d=0x10, quot=62 (0x3E), rem=8. The exact build on the same operands gives quot=32, rem=8.
- start held high through RUN, with a second start in the DONE cycle -> mid-RUN starts are ignored; the second operation is accepted back-to-back and its done arrives exactly 9 cycles after the first done.
- rst asserted at the 4th RUN cycle -> next cycle all outputs are 0 and state is IDLE; a fresh 0x03E8 / 0x07 then completes correctly.
